alu_input_sequencer: RTL

//  Operator-side front end for the registered 16-bit ALU. Debounces the ENTER and UNDO buttons
//  and steps a 4-state FSM that captures the switch word as operand A, then operand B, then opcode.

---
 rtl/alu_input_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_input_sequencer.sv
// Operator front end for the registered ALU: synchronizes switches and buttons, debounces
// ENTER/UNDO and steps a one-hot FSM that issues aligned load/update strobes with the data word.
module alu_input_sequencer #(
  parameter int N          = 16,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_in,
  input  logic         btn_enter,
  input  logic         btn_undo,
  output logic [N-1:0] data_out,
  output logic         load_A,
  output logic         load_B,
  output logic         load_Op,
  output logic         updateRes,
  output logic [3:0]   state_onehot
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [3:0] {
    WAIT_A  = 4'b0001,
    WAIT_B  = 4'b0010,
    WAIT_OP = 4'b0100,
    SHOW    = 4'b1000
  } state_t;

  logic [N-1:0]     sw_meta_r;
  logic [N-1:0]     sw_sync_r;
  logic [1:0]       btn_raw_s;
  logic [1:0]       btn_meta_r;
  logic [1:0]       btn_sync_r;
  logic [1:0]       deb_r;
  logic [1:0]       deb_q_r;
  logic [CNT_W-1:0] cnt_r [2];
  logic             press_enter_s;
  logic             press_undo_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             ld_a_s;
  logic             ld_b_s;
  logic             ld_op_s;
  logic             capture_s;
  logic [N-1:0]     data_r;
  logic             ld_a_r;
  logic             ld_b_r;
  logic             ld_op_r;
  logic             upd_r;

  // Bit 0 carries ENTER, bit 1 carries UNDO through the shared synchronizer/debouncer.
  assign btn_raw_s = {btn_undo, btn_enter};

  // Two-flop synchronizers for the switch word and both buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
      btn_meta_r <= 2'b00;
      btn_sync_r <= 2'b00;
    end else begin
      sw_meta_r  <= sw_in;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= btn_raw_s;
      btn_sync_r <= btn_meta_r;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_deb
    // Accept a new level only after it has differed from the debounced level for DEB_CYCLES edges.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_r[b]   <= '0;
        deb_r[b]   <= 1'b0;
        deb_q_r[b] <= 1'b0;
      end else begin
        deb_q_r[b] <= deb_r[b];
        if (btn_sync_r[b] == deb_r[b]) begin
          cnt_r[b] <= '0;
        end else if (cnt_r[b] == CNT_MAX) begin
          deb_r[b] <= btn_sync_r[b];
          cnt_r[b] <= '0;
        end else begin
          cnt_r[b] <= cnt_r[b] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign press_enter_s = deb_r[0] & ~deb_q_r[0];
  assign press_undo_s  = deb_r[1] & ~deb_q_r[1];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; UNDO takes priority over a coincident ENTER.
  always_comb begin
    state_nxt_s = state_r;
    if (press_undo_s) begin
      case (state_r)
        WAIT_A:  state_nxt_s = WAIT_A;
        WAIT_B:  state_nxt_s = WAIT_A;
        WAIT_OP: state_nxt_s = WAIT_B;
        SHOW:    state_nxt_s = WAIT_OP;
        default: state_nxt_s = WAIT_A;
      endcase
    end else if (press_enter_s) begin
      case (state_r)
        WAIT_A:  state_nxt_s = WAIT_B;
        WAIT_B:  state_nxt_s = WAIT_OP;
        WAIT_OP: state_nxt_s = SHOW;
        SHOW:    state_nxt_s = WAIT_A;
        default: state_nxt_s = WAIT_A;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Strobe decode: only an accepted ENTER in a capture state loads the ALU.
  always_comb begin
    ld_a_s  = 1'b0;
    ld_b_s  = 1'b0;
    ld_op_s = 1'b0;
    if (press_enter_s && !press_undo_s) begin
      case (state_r)
        WAIT_A:  ld_a_s  = 1'b1;
        WAIT_B:  ld_b_s  = 1'b1;
        WAIT_OP: ld_op_s = 1'b1;
        default: ld_a_s  = 1'b0;
      endcase
    end else begin
      ld_a_s = 1'b0;
    end
  end

  assign capture_s = ld_a_s | ld_b_s | ld_op_s;

  // Strobes and data word registered together so the ALU sees them aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r  <= '0;
      ld_a_r  <= 1'b0;
      ld_b_r  <= 1'b0;
      ld_op_r <= 1'b0;
      upd_r   <= 1'b0;
    end else begin
      ld_a_r  <= ld_a_s;
      ld_b_r  <= ld_b_s;
      ld_op_r <= ld_op_s;
      upd_r   <= ld_op_r;
      if (capture_s) begin
        data_r <= sw_sync_r;
      end
    end
  end

  assign data_out     = data_r;
  assign load_A       = ld_a_r;
  assign load_B       = ld_b_r;
  assign load_Op      = ld_op_r;
  assign updateRes    = upd_r;
  assign state_onehot = state_r;

endmodule
